axi_read_burst_engine: RTL and testbench
========================================

AXI_READ_BURST_ENGINE -- requirements
Module: axi_read_burst_engine

Interface
REQ-001 The block SHALL have one clock, ACLK, and a synchronous active-low reset, ARESETn.
REQ-002 Parameter ID_WIDTH SHALL default to 2 and set the width of the slave-side ARID/RID.
REQ-003 Parameter MEM_AWIDTH SHALL default to 7 and give the number of valid memory byte-address bits.
REQ-004 ACLK  input  1  clock; all state changes on its rising edge.
REQ-005 ARESETn  input  1  synchronous active-low reset.
REQ-006 ARID  input  ID_WIDTH  read burst ID.
REQ-007 ARADDR  input  32  start byte address.
REQ-008 ARLEN  input  4  beats minus one.
REQ-009 ARSIZE  input  2  bytes per beat = 1<<ARSIZE.
REQ-010 ARBURST  input  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-011 ARVALID  input  1  AR request valid.
REQ-012 ARREADY  output  1  AR request accepted.
REQ-013 RID  output  ID_WIDTH  ID of the burst being returned.
REQ-014 RDATA  output  32  read beat data.
REQ-015 RRESP  output  2  00 OKAY, 10 SLVERR, 11 DECERR.
REQ-016 RLAST  output  1  final beat of the burst.
REQ-017 RVALID  output  1  R beat valid.
REQ-018 RREADY  input  1  master accepts the R beat.
REQ-019 address_out  output  32  memory byte address, registered.
REQ-020 memread  output  1  memory read strobe.
REQ-021 data_in  input  32  memory read data, valid in the cycle after the memread cycle.

Function
REQ-022 The FSM SHALL have the states IDLE, READ, DATA and RESP, and ARREADY SHALL be 1 only in IDLE, so one burst is outstanding at a time.
REQ-023 IDLE SHALL, on an ARVALID&&ARREADY edge, latch ID/ADDR/LEN/SIZE/BURST, load beat_cnt=ARLEN and compute the response, then go to READ (OKAY) or RESP (error).
REQ-024 The error check SHALL give DECERR if ARADDR[31:MEM_AWIDTH]!=0, else SLVERR if ARSIZE==11, ARBURST==11, or WRAP with ARLEN not in {1,3,7,15}, else OKAY.
REQ-025 READ SHALL last one cycle with memread=1 and address_out=cur_addr, then go to DATA; memread SHALL be 0 in every other state.
REQ-026 DATA SHALL last one cycle, register data_in into RDATA masked by size (00: {24'b0,byte0}; 01: {16'b0,half0}; 10: full word), then go to RESP.
REQ-027 RESP SHALL hold RVALID=1 with RDATA/RID/RRESP/RLAST stable until RREADY=1 at a rising edge.
REQ-028 RLAST SHALL be 1 exactly when beat_cnt==0.
REQ-029 On an RESP handshake with RLAST=1 the FSM SHALL go to IDLE; otherwise it SHALL decrement beat_cnt, advance cur_addr, and go to READ (OKAY) or stay in RESP (error).
REQ-030 Error bursts SHALL still return ARLEN+1 beats with RDATA=0 and the latched RRESP, and SHALL never assert memread.
REQ-031 Address advance SHALL be: FIXED unchanged; INCR cur_addr+(1<<size), 32-bit with no 4KB check.
REQ-032 WRAP advance SHALL be: bytes=(len+1)<<size, base=cur_addr&~(bytes-1), next=base|((cur_addr+(1<<size))&(bytes-1)).
REQ-033 Latency SHALL be: RVALID rises 2 edges after the AR acceptance edge (OKAY) or 1 edge after it (error); after each non-last handshake the next RVALID rises 2 edges later (OKAY), for a minimum of 3 cycles per beat.
REQ-034 RVALID SHALL go low on the edge after the last beat's handshake, and ARREADY SHALL rise on that same edge.
REQ-035 ARREADY SHALL NOT depend combinationally on ARVALID or RREADY.
REQ-036 If ARVALID is asserted outside IDLE it SHALL be ignored until IDLE (AR payload held by the master per AXI).

Reset
REQ-037 While ARESETn=0 at a rising edge: state=IDLE; ARREADY=1 after release; RVALID, RLAST, memread=0; RDATA, RID, RRESP, address_out, cur_addr, beat_cnt=0.
REQ-038 A reset asserted mid-burst SHALL abandon the burst with no further R beats, and the first edge with ARESETn=1 SHALL be able to accept a new AR.

Verification
REQ-039 INCR: ARADDR=0x00, ARLEN=3, ARSIZE=01 -> address_out 0x00,0x02,0x04,0x06, four beats of RDATA[31:16]=0, RLAST on beat 4, RRESP=00, RID echoes ARID.
REQ-040 WRAP: ARADDR=0x0C, ARLEN=3, ARSIZE=10 -> address_out 0x0C,0x00,0x04,0x08, with full-word RDATA.
REQ-041 FIXED: ARADDR=0x14, ARLEN=2, ARSIZE=00 -> memread three times at 0x14, RDATA=mem[0x14] zero-extended, RLAST on beat 3.
REQ-042 Backpressure: RREADY=0 for 5 cycles on beat 2 of INCR len=1 -> RVALID/RDATA/RLAST stable, no memread, ARREADY=0 throughout.
REQ-043 Errors: ARSIZE=11 len=3 -> 4 beats RRESP=10, RDATA=0, memread never 1; ARADDR=0x80 len=0 -> 1 beat RRESP=11, RLAST=1.
REQ-044 Reset mid-burst: ARESETn=0 for 1 edge during beat 2 of 4 -> all outputs zero, no further RVALID; a new AR accepted immediately after release completes correctly.

Source files
------------

// File: rtl/axi_read_burst_engine.sv
// AXI read burst engine: one outstanding AR burst, one beat per memory read.
// FIXED/INCR/WRAP addressing with DECERR/SLVERR bursts returned without memory access.
module axi_read_burst_engine #(
    parameter int ID_WIDTH   = 2,
    parameter int MEM_AWIDTH = 7
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_WIDTH-1:0] ARID,
    input  logic [31:0]         ARADDR,
    input  logic [3:0]          ARLEN,
    input  logic [1:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_WIDTH-1:0] RID,
    output logic [31:0]         RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [31:0]         address_out,
    output logic                memread,
    input  logic [31:0]         data_in
);

    typedef enum logic [1:0] {IDLE, READ, DATA, RESP} state_t;

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] id_q;
    logic [31:0]         cur_addr;
    logic [3:0]          len_q;
    logic [3:0]          beat_cnt;
    logic [1:0]          size_q;
    logic [1:0]          burst_q;
    logic [1:0]          resp_q;
    logic [31:0]         rdata_q;
    logic [1:0]          ar_resp;
    logic [31:0]         step;
    logic [31:0]         wrap_mask;
    logic [31:0]         incr_addr;
    logic [31:0]         nxt_addr;
    logic [31:0]         data_masked;
    logic                r_hs;

    assign ARREADY = (state == IDLE);
    assign RVALID  = (state == RESP);
    assign memread = (state == READ);
    assign RLAST   = RVALID && (beat_cnt == 4'd0);
    assign RID     = id_q;
    assign RRESP   = resp_q;
    assign RDATA   = rdata_q;
    assign r_hs    = RVALID && RREADY;

    always_comb begin
        ar_resp = 2'b00;
        if ((ARADDR >> MEM_AWIDTH) != 32'd0) begin
            ar_resp = 2'b11;
        end else if (ARSIZE == 2'b11 || ARBURST == 2'b11 ||
                     (ARBURST == 2'b10 &&
                      !(ARLEN == 4'd1 || ARLEN == 4'd3 ||
                        ARLEN == 4'd7 || ARLEN == 4'd15))) begin
            ar_resp = 2'b10;
        end
    end

    // WRAP keeps the upper address bits and wraps the low bits inside the burst window
    assign step      = 32'd1 << size_q;
    assign wrap_mask = ((32'({len_q}) + 32'd1) << size_q) - 32'd1;
    assign incr_addr = cur_addr + step;

    always_comb begin
        nxt_addr = incr_addr;
        unique case (burst_q)
            2'b00:   nxt_addr = cur_addr;
            2'b10:   nxt_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default: nxt_addr = incr_addr;
        endcase
    end

    always_comb begin
        data_masked = data_in;
        unique case (size_q)
            2'b00:   data_masked = {24'd0, data_in[7:0]};
            2'b01:   data_masked = {16'd0, data_in[15:0]};
            default: data_masked = data_in;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (ARVALID) state_nxt = (ar_resp == 2'b00) ? READ : RESP;
            READ: state_nxt = DATA;
            DATA: state_nxt = RESP;
            RESP: begin
                if (RREADY) begin
                    if (RLAST)                 state_nxt = IDLE;
                    else if (resp_q == 2'b00) state_nxt = READ;
                    else                       state_nxt = RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            id_q        <= '0;
            cur_addr    <= '0;
            len_q       <= '0;
            beat_cnt    <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            resp_q      <= '0;
            rdata_q     <= '0;
            address_out <= '0;
        end else begin
            if (state == IDLE && ARVALID) begin
                id_q        <= ARID;
                cur_addr    <= ARADDR;
                len_q       <= ARLEN;
                beat_cnt    <= ARLEN;
                size_q      <= ARSIZE;
                burst_q     <= ARBURST;
                resp_q      <= ar_resp;
                rdata_q     <= '0;
                address_out <= ARADDR;
            end
            if (state == DATA) rdata_q <= data_masked;
            if (r_hs && !RLAST) begin
                beat_cnt <= beat_cnt - 4'd1;
                cur_addr <= nxt_addr;
                if (resp_q == 2'b00) address_out <= nxt_addr;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_burst_engine.sv
// Scoreboard bench for axi_read_burst_engine: expected beats and memory
// addresses are queued when an AR is issued and consumed as the DUT responds.
module tb_axi_read_burst_engine;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [1:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [3:0]  ARLEN = '0;
    logic [1:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [1:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b1;
    logic [31:0] address_out;
    logic        memread;
    logic [31:0] data_in = '0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [1:0]  id;
    } beat_t;

    beat_t       rq[$];
    logic [31:0] aq[$];
    int          n_checks = 0;
    int          n_errors = 0;

    axi_read_burst_engine #(.ID_WIDTH(2), .MEM_AWIDTH(7)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .address_out(address_out), .memread(memread), .data_in(data_in)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hA5 ^ a[7:0], 8'h3C, 8'h5A ^ a[7:0], a[7:0] + 8'h11};
    endfunction

    // memory answers one cycle after the read strobe
    always @(posedge ACLK) data_in <= memread ? mem_word(address_out) : 32'hDEADBEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    always @(negedge ACLK) begin
        if (ARESETn && memread) begin
            if (aq.size() == 0) check("memread_unexpected", 32'd1, 32'd0);
            else                check("address_out", address_out, aq.pop_front());
        end
    end

    task automatic wait_rvalid(input int exp_wait, output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!RVALID && n < 20);
        ok = RVALID;
        if (!ok) check("rvalid_timeout", 32'd0, 32'd1);
        else     check("rvalid_latency", n, exp_wait);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rvalid"}, RVALID, 0);
        check({tag, "_rlast"}, RLAST, 0);
        check({tag, "_memread"}, memread, 0);
        check({tag, "_rdata"}, RDATA, 0);
        check({tag, "_rid"}, RID, 0);
        check({tag, "_rresp"}, RRESP, 0);
        check({tag, "_addr"}, address_out, 0);
    endtask

    // called at a negedge; returns at a negedge
    task automatic run_burst(input logic [1:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [1:0] size,
                             input logic [1:0] burst, input int stall_beat,
                             input int stall_n, input int abort_beat);
        logic [31:0] a, step, wmask, word;
        logic [1:0]  resp;
        beat_t       b, snap;
        bit          ok;
        resp = 2'b00;
        if (addr[31:7] != 0) resp = 2'b11;
        else if (size == 2'b11 || burst == 2'b11 ||
                 (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)))
            resp = 2'b10;
        step  = 32'd1 << size;
        wmask = ((32'(len) + 1) << size) - 1;
        a     = addr;
        for (int i = 0; i <= int'(len); i++) begin
            word = mem_word(a);
            if (size == 2'b00)      word = word & 32'h0000_00FF;
            else if (size == 2'b01) word = word & 32'h0000_FFFF;
            if (resp == 2'b00) aq.push_back(a);
            b.data = (resp == 2'b00) ? word : 32'd0;
            b.resp = resp;
            b.last = (i == int'(len));
            b.id   = id;
            rq.push_back(b);
            case (burst)
                2'b00:   a = a;
                2'b10:   a = (a & ~wmask) | ((a + step) & wmask);
                default: a = a + step;
            endcase
        end
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARVALID = 1'b1;
        check("arready_idle", ARREADY, 1);
        @(posedge ACLK);
        #1 ARVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wait_rvalid((resp == 2'b00) ? 3 : 1, ok);
            if (!ok) begin rq.delete(); aq.delete(); return; end
            if (i == abort_beat) begin
                ARESETn = 1'b0;
                @(negedge ACLK);
                check_reset_outputs("midrst");
                ARESETn = 1'b1;
                rq.delete();
                aq.delete();
                return;
            end
            if (i == stall_beat) begin
                RREADY = 1'b0;
                snap = '{RDATA, RRESP, RLAST, RID};
                repeat (stall_n) begin
                    @(negedge ACLK);
                    check("stall_rvalid", RVALID, 1);
                    check("stall_rdata", RDATA, snap.data);
                    check("stall_rlast", RLAST, snap.last);
                    check("stall_memread", memread, 0);
                    check("stall_arready", ARREADY, 0);
                end
                RREADY = 1'b1;
            end
            b = rq.pop_front();
            check("rdata", RDATA, b.data);
            check("rresp", RRESP, b.resp);
            check("rlast", RLAST, b.last);
            check("rid", RID, b.id);
        end
        @(negedge ACLK);
        check("rvalid_after_last", RVALID, 0);
        check("arready_after_last", ARREADY, 1);
    endtask

    initial begin
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_reset_outputs("reset");
        ARESETn = 1'b1;
        run_burst(2'd1, 32'h00, 4'd3, 2'b01, 2'b01, -1, 0, -1);
        run_burst(2'd2, 32'h0C, 4'd3, 2'b10, 2'b10, -1, 0, -1);
        run_burst(2'd3, 32'h14, 4'd2, 2'b00, 2'b00, -1, 0, -1);
        run_burst(2'd0, 32'h20, 4'd1, 2'b10, 2'b01, 1, 5, -1);
        run_burst(2'd1, 32'h30, 4'd3, 2'b11, 2'b01, -1, 0, -1);
        run_burst(2'd2, 32'h80, 4'd0, 2'b10, 2'b01, -1, 0, -1);
        run_burst(2'd3, 32'h10, 4'd2, 2'b10, 2'b10, -1, 0, -1);
        run_burst(2'd0, 32'h10, 4'd1, 2'b00, 2'b11, -1, 0, -1);
        run_burst(2'd1, 32'h05, 4'd1, 2'b00, 2'b10, -1, 0, -1);
        run_burst(2'd2, 32'h38, 4'd7, 2'b00, 2'b10, 2, 3, -1);
        run_burst(2'd3, 32'h40, 4'd3, 2'b10, 2'b01, -1, 0, 1);
        run_burst(2'd2, 32'h44, 4'd1, 2'b10, 2'b01, -1, 0, -1);
        for (int k = 0; k < 6; k++) begin
            run_burst(2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)),
                      4'($urandom_range(0, 15)), 2'($urandom_range(0, 2)),
                      2'b01, int'($urandom_range(0, 3)), 2, -1);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d exp 0", 1);
        $fatal(1, "timeout");
    end

endmodule
